router_rx_nsyn: RTL



---
 rtl/router_rx_nsyn_pkg.sv | 31 +++
 rtl/router_rx_nsyn_if.sv | 30 +++
 rtl/router_rx_nsyn_fifo2.sv | 94 +++++++++
 rtl/router_rx_nsyn.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/router_rx_nsyn_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router byte-serial receiver:
//   - word width and beats-per-word helper
//   - assembly state encoding
//   - status register bit positions and bus address decodes
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int WORD_W = 128;

  // Status register layout: {.., ferr, ovr, count[1:0]}
  localparam int STAT_CNT_LO = 0;
  localparam int STAT_OVR    = 2;
  localparam int STAT_FERR   = 3;

  // Single address bit selects data or status
  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_STAT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ASM  = 1'b1
  } asm_state_e;

  // Number of beats needed to carry one WORD_W-bit word, p bits per beat.
  function automatic int beats_for(input int p);
    return (WORD_W + p - 1) / p;
  endfunction

endpackage

// File: rtl/router_rx_nsyn_if.sv
// -----------------------------------------------------------------------------
// router_rx_nsyn_if
// WISHBONE-style slave bus bundle for the router receiver.
//   cs_i, cyc_i, stb_i : select / cycle / strobe from the SoC
//   we_i               : write enable (writes are acked and ignored)
//   adr_i              : 0 = data register, 1 = status register
//   ack_o              : transfer acknowledge
//   dat_o              : 128-bit read data
// -----------------------------------------------------------------------------
interface router_rx_nsyn_if;

  logic         cs_i;
  logic         cyc_i;
  logic         stb_i;
  logic         we_i;
  logic         adr_i;
  logic         ack_o;
  logic [127:0] dat_o;

  modport master (
    output cs_i, cyc_i, stb_i, we_i, adr_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  cs_i, cyc_i, stb_i, we_i, adr_i,
    output ack_o, dat_o
  );

endinterface

// File: rtl/router_rx_nsyn_fifo2.sv
// -----------------------------------------------------------------------------
// router_fifo2
// Two-entry FIFO holding reassembled words.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write din_i at the tail
//   pop_i        : drop the head (ignored when empty)
//   din_i        : word to push
//   head_o       : oldest word (stale when count_o == 0)
//   count_o      : number of stored words, 0..2
//   ovf_o        : a push was dropped because both entries stayed occupied
// A simultaneous push and pop keeps the count and preserves order; a pop in
// the same cycle frees a slot, so a push at count 2 with a pop is accepted.
// -----------------------------------------------------------------------------
module router_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         ovf_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_s;
  logic         ovf_s;

  assign pop_s = pop_i & (cnt_q != 2'd0);

  // Next-state for the two slots and the occupancy count.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    ovf_s  = 1'b0;
    case ({push_i, pop_s})
      2'b10: begin
        case (cnt_q)
          2'd0: begin
            mem0_d = din_i;
            cnt_d  = 2'd1;
          end
          2'd1: begin
            mem1_d = din_i;
            cnt_d  = 2'd2;
          end
          default: begin
            ovf_s = 1'b1;
          end
        endcase
      end
      2'b01: begin
        // Slot 1 moves to the head; with one word left this only
        // refreshes the now-stale head.
        mem0_d = mem1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          mem0_d = mem1_q;
          mem1_d = din_i;
        end else begin
          mem0_d = din_i;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Slot and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = mem0_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_s;

endmodule

// File: rtl/router_rx_nsyn.sv
// -----------------------------------------------------------------------------
// router_rx_nsyn
// Receiver for the router's N-bit-parallel serial link. Reassembles 128-bit
// words from pBitsParallel-wide beats (least-significant chunk first), buffers
// them in a 2-entry FIFO and exposes them on a WISHBONE slave port.
//   clk_i, rst_i : serial/bus clock, asynchronous active-high reset
//   wb           : bus slave (cs/cyc/stb/we/adr in, ack/dat out)
//   rxd          : data beat
//   sync         : marks the beat carrying chunk 0 of a word
//   cts          : clear-to-send back to the transmitter
//   empty        : FIFO holds no words
//   irq_o        : words available (~empty)
// -----------------------------------------------------------------------------
module router_rx_nsyn
  import router_pkg::*;
#(
  parameter int pBitsParallel = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  router_rx_nsyn_if.slave          wb,
  input  logic [pBitsParallel-1:0] rxd,
  input  logic                     sync,
  output logic                     cts,
  output logic                     empty,
  output logic                     irq_o
);

  localparam int pBeats = beats_for(pBitsParallel);
  localparam int SR_W   = pBeats * pBitsParallel;
  localparam int BEAT_W = $clog2(pBeats);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(pBeats - 1);

  asm_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]   shift_s;
  logic              push_s;
  logic              ferr_set_s;

  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;

  logic              ack_s;
  logic              rd_s;
  logic              pop_s;
  logic              stat_rd_s;
  logic              ovf_s;
  logic [1:0]        count_s;
  logic [WORD_W-1:0] head_s;
  logic [WORD_W-1:0] stat_s;
  logic [WORD_W-1:0] dat_s;

  // New beats enter at the top so chunk 0 ends up in the low bits.
  assign shift_s = {rxd, sr_q[SR_W-1:pBitsParallel]};

  // Assembly FSM: next state, beat counter and shift register.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    sr_d       = sr_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          sr_d    = shift_s;
          beat_d  = BEAT_W'(1);
          state_d = ST_ASM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASM: begin
        if (sync) begin
          // Early sync: restart on this beat. The stale partial word is
          // simply shifted out by the beats that follow.
          ferr_set_s = 1'b1;
          sr_d       = shift_s;
          beat_d     = BEAT_W'(1);
        end else if (beat_q == LAST_BEAT) begin
          push_s  = 1'b1;
          sr_d    = shift_s;
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          sr_d   = shift_s;
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Assembly registers; the shift register idles at all ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      sr_q    <= '1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sr_q    <= sr_d;
    end
  end

  router_fifo2 #(
    .W (WORD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (shift_s[WORD_W-1:0]),
    .head_o  (head_s),
    .count_o (count_s),
    .ovf_o   (ovf_s)
  );

  assign ack_s     = wb.cyc_i & wb.stb_i & wb.cs_i;
  assign rd_s      = ack_s & ~wb.we_i;
  assign pop_s     = rd_s & (wb.adr_i == ADR_DATA) & (count_s != 2'd0);
  assign stat_rd_s = rd_s & (wb.adr_i == ADR_STAT);

  // Sticky error flags: a new error in the same cycle beats the clearing read.
  always_comb begin
    if (ovf_s) begin
      ovr_d = 1'b1;
    end else if (stat_rd_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (ferr_set_s) begin
      ferr_d = 1'b1;
    end else if (stat_rd_s) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  // Read data mux: FIFO head or status word.
  always_comb begin
    stat_s                     = '0;
    stat_s[STAT_CNT_LO +: 2]   = count_s;
    stat_s[STAT_OVR]           = ovr_q;
    stat_s[STAT_FERR]          = ferr_q;
    if (wb.adr_i == ADR_STAT) begin
      dat_s = stat_s;
    end else begin
      dat_s = head_s;
    end
  end

  assign wb.ack_o = ack_s;
  assign wb.dat_o = dat_s;

  // With one word stored, a word completing now fills the FIFO unless a pop
  // frees the head in the same cycle. Depends only on registers, sync and
  // bus inputs, never on rxd.
  assign cts = (count_s == 2'd0)
             | ((count_s == 2'd1) & ~push_s)
             | ((count_s == 2'd1) & pop_s);

  assign empty = (count_s == 2'd0);
  assign irq_o = ~empty;

endmodule
